// File: rtl/b_mdu_if.sv
// rtl/b_mdu_if.sv - request/result signal bundle between the pipeline and the MDU
// Purpose: groups the MDU operation request and result signals.
// Ports (slave view = MDU):
//   i_b_mdu_start      in   operation request (sampled only in IDLE)
//   i_b_mdu_op[2:0]    in   opcode: MULT, MULTU, DIV, DIVU, MTHI, MTLO
//   i_b_mdu_operand_1  in   rs value
//   i_b_mdu_operand_2  in   rt value
//   i_b_mdu_flush      in   aborts an in-flight operation
//   o_b_mdu_busy       out  stall request while iterating
//   o_b_mdu_done       out  one-cycle completion pulse
//   o_b_mdu_hi/lo      out  architectural HI/LO
//   o_b_mdu_div_zero   out  divide-by-zero flag, valid with done
interface b_mdu_if;
   logic        i_b_mdu_start;
   logic [2:0]  i_b_mdu_op;
   logic [31:0] i_b_mdu_operand_1;
   logic [31:0] i_b_mdu_operand_2;
   logic        i_b_mdu_flush;
   logic        o_b_mdu_busy;
   logic        o_b_mdu_done;
   logic [31:0] o_b_mdu_hi;
   logic [31:0] o_b_mdu_lo;
   logic        o_b_mdu_div_zero;

   modport master (
      output i_b_mdu_start, i_b_mdu_op, i_b_mdu_operand_1, i_b_mdu_operand_2, i_b_mdu_flush,
      input  o_b_mdu_busy, o_b_mdu_done, o_b_mdu_hi, o_b_mdu_lo, o_b_mdu_div_zero
   );

   modport slave (
      input  i_b_mdu_start, i_b_mdu_op, i_b_mdu_operand_1, i_b_mdu_operand_2, i_b_mdu_flush,
      output o_b_mdu_busy, o_b_mdu_done, o_b_mdu_hi, o_b_mdu_lo, o_b_mdu_div_zero
   );
endinterface

// File: rtl/b_mdu.sv
// rtl/b_mdu.sv - iterative 32-bit multiply/divide unit with HI/LO registers
// Purpose: MIPS-style MDU. MULT/MULTU via radix-2 shift-add, DIV/DIVU via
//          restoring shift-subtract, one iteration per cycle, sign fix-up in
//          a final FIX cycle. MTHI/MTLO write HI/LO directly.
// Ports:
//   i_b_mdu_clk   in   clock, rising edge
//   i_b_mdu_rst   in   asynchronous active-high reset
//   mdu           b_mdu_if.slave request/result bundle
module b_mdu (
   input  logic     i_b_mdu_clk,
   input  logic     i_b_mdu_rst,
   b_mdu_if.slave   mdu
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        last_q, last_d;       // set once the counter has wrapped
   logic        is_div_q, is_div_d;
   logic        neg_q, neg_d;         // product/quotient must be negated
   logic        rem_neg_q, rem_neg_d; // remainder takes dividend sign
   // acc_hi/acc_lo: MUL = {partial product high, multiplier/product low}
   //                DIV = {partial remainder, dividend shifting into quotient}
   logic [31:0] acc_hi_q, acc_hi_d;
   logic [31:0] acc_lo_q, acc_lo_d;
   logic [31:0] opb_q, opb_d;         // multiplicand or divisor magnitude
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;
   logic        div_zero_q, div_zero_d;

   logic        op_signed;
   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic        div_ok;
   logic [63:0] prod_raw, prod_fix;
   logic [31:0] quot_fix, rem_fix;

   // Signed ops work on magnitudes; 0x80000000 stays 0x80000000 as unsigned.
   assign op_signed = ~mdu.i_b_mdu_op[0];
   assign a_mag = (op_signed && mdu.i_b_mdu_operand_1[31]) ? (32'd0 - mdu.i_b_mdu_operand_1)
                                                           : mdu.i_b_mdu_operand_1;
   assign b_mag = (op_signed && mdu.i_b_mdu_operand_2[31]) ? (32'd0 - mdu.i_b_mdu_operand_2)
                                                           : mdu.i_b_mdu_operand_2;

   assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
   assign div_shift = {acc_hi_q, acc_lo_q[31]};
   assign div_diff  = div_shift - {1'b0, opb_q};
   // Partial remainder is always below the divisor, so bit 32 is a pure borrow.
   assign div_ok    = ~div_diff[32];

   assign prod_raw = {acc_hi_q, acc_lo_q};
   assign prod_fix = neg_q ? (64'd0 - prod_raw) : prod_raw;
   assign quot_fix = neg_q ? (32'd0 - acc_lo_q) : acc_lo_q;
   assign rem_fix  = rem_neg_q ? (32'd0 - acc_hi_q) : acc_hi_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      is_div_d   = is_div_q;
      neg_d      = neg_q;
      rem_neg_d  = rem_neg_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      opb_d      = opb_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;

      case (state_q)
         S_IDLE: begin
            if (mdu.i_b_mdu_start && !mdu.i_b_mdu_flush) begin
               case (mdu.i_b_mdu_op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     if (mdu.i_b_mdu_op[1] && (mdu.i_b_mdu_operand_2 == 32'd0)) begin
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                     end else begin
                        is_div_d  = mdu.i_b_mdu_op[1];
                        neg_d     = op_signed & (mdu.i_b_mdu_operand_1[31] ^ mdu.i_b_mdu_operand_2[31]);
                        rem_neg_d = op_signed & mdu.i_b_mdu_operand_1[31];
                        cnt_d     = 5'd0;
                        last_d    = 1'b0;
                        acc_hi_d  = 32'd0;
                        if (mdu.i_b_mdu_op[1]) begin
                           acc_lo_d = a_mag;
                           opb_d    = b_mag;
                           state_d  = S_DIV;
                        end else begin
                           acc_lo_d = b_mag;
                           opb_d    = a_mag;
                           state_d  = S_MUL;
                        end
                     end
                  end
                  OP_MTHI: begin
                     hi_d       = mdu.i_b_mdu_operand_1;
                     done_d     = 1'b1;
                     div_zero_d = 1'b0;
                  end
                  OP_MTLO: begin
                     lo_d       = mdu.i_b_mdu_operand_1;
                     done_d     = 1'b1;
                     div_zero_d = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         S_MUL, S_DIV: begin
            if (mdu.i_b_mdu_flush) begin
               state_d = S_IDLE;
               cnt_d   = 5'd0;
               last_d  = 1'b0;
            end else if (last_q) begin
               state_d = S_FIX;
               last_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  last_d = 1'b1;
               end
               if (state_q == S_MUL) begin
                  {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[31:1]};
               end else begin
                  acc_hi_d = div_ok ? div_diff[31:0] : div_shift[31:0];
                  acc_lo_d = {acc_lo_q[30:0], div_ok};
               end
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
            if (!mdu.i_b_mdu_flush) begin
               if (is_div_q) begin
                  lo_d = quot_fix;
                  hi_d = rem_fix;
               end else begin
                  hi_d = prod_fix[63:32];
                  lo_d = prod_fix[31:0];
               end
               done_d     = 1'b1;
               div_zero_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_b_mdu_clk or posedge i_b_mdu_rst) begin
      if (i_b_mdu_rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 5'd0;
         last_q     <= 1'b0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         acc_hi_q   <= 32'd0;
         acc_lo_q   <= 32'd0;
         opb_q      <= 32'd0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         is_div_q   <= is_div_d;
         neg_q      <= neg_d;
         rem_neg_q  <= rem_neg_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         opb_q      <= opb_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign mdu.o_b_mdu_busy     = (state_q != S_IDLE);
   assign mdu.o_b_mdu_done     = done_q;
   assign mdu.o_b_mdu_hi       = hi_q;
   assign mdu.o_b_mdu_lo       = lo_q;
   assign mdu.o_b_mdu_div_zero = div_zero_q;

endmodule

// File: tb/tb_b_mdu.sv
// tb/tb_b_mdu.sv - directed self-checking bench for b_mdu
module tb_b_mdu;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   b_mdu_if mif ();

   b_mdu dut (
      .i_b_mdu_clk (clk),
      .i_b_mdu_rst (rst),
      .mdu         (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues one request, then samples at each falling edge until busy is low.
   // inject: 0 none, 1 extra start at busy cycle 5, 2 flush at busy cycle 10.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inject, output int bcyc, output logic dn, output logic dz);
      @(negedge clk);
      mif.i_b_mdu_start     = 1'b1;
      mif.i_b_mdu_op        = op;
      mif.i_b_mdu_operand_1 = a;
      mif.i_b_mdu_operand_2 = b;
      @(posedge clk);
      #1;
      mif.i_b_mdu_start = 1'b0;
      bcyc = 0;
      dn   = 1'b0;
      dz   = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         mif.i_b_mdu_start = 1'b0;
         mif.i_b_mdu_flush = 1'b0;
         if (mif.o_b_mdu_busy) begin
            bcyc++;
            if (inject == 1 && bcyc == 5) begin
               mif.i_b_mdu_start     = 1'b1;
               mif.i_b_mdu_op        = 3'b100;
               mif.i_b_mdu_operand_1 = 32'hDEADBEEF;
            end
            if (inject == 2 && bcyc == 10) begin
               mif.i_b_mdu_flush = 1'b1;
            end
         end else begin
            dn = mif.o_b_mdu_done;
            dz = mif.o_b_mdu_div_zero;
            break;
         end
      end
   endtask

   int   bc;
   logic dn, dz;
   logic seen_done;

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      mif.i_b_mdu_start     = 1'b0;
      mif.i_b_mdu_op        = 3'b000;
      mif.i_b_mdu_operand_1 = 32'd0;
      mif.i_b_mdu_operand_2 = 32'd0;
      mif.i_b_mdu_flush     = 1'b0;

      // Reset state, with start asserted during reset (must be ignored)
      #12;
      mif.i_b_mdu_start = 1'b1;
      mif.i_b_mdu_op    = 3'b100;
      mif.i_b_mdu_operand_1 = 32'h55555555;
      @(negedge clk);
      chk("rst_hi", mif.o_b_mdu_hi, 0);
      chk("rst_lo", mif.o_b_mdu_lo, 0);
      chk("rst_busy", mif.o_b_mdu_busy, 0);
      chk("rst_done", mif.o_b_mdu_done, 0);
      chk("rst_dz", mif.o_b_mdu_div_zero, 0);
      mif.i_b_mdu_start = 1'b0;
      rst = 1'b0;

      // MTHI / MTLO preload
      do_op(3'b100, 32'h11111111, 32'd0, 0, bc, dn, dz);
      chk("mthi_busy", bc, 0);
      chk("mthi_done", dn, 1);
      chk("mthi_hi", mif.o_b_mdu_hi, 64'h11111111);
      do_op(3'b101, 32'h22222222, 32'd0, 0, bc, dn, dz);
      chk("mtlo_done", dn, 1);
      chk("mtlo_lo", mif.o_b_mdu_lo, 64'h22222222);
      @(negedge clk);
      chk("done_one_cycle", mif.o_b_mdu_done, 0);

      // DIV 5 / 0
      do_op(3'b010, 32'd5, 32'd0, 0, bc, dn, dz);
      chk("dz_busy", bc, 0);
      chk("dz_done", dn, 1);
      chk("dz_flag", dz, 1);
      chk("dz_hi", mif.o_b_mdu_hi, 64'h11111111);
      chk("dz_lo", mif.o_b_mdu_lo, 64'h22222222);

      // MULT 7 * -3
      do_op(3'b000, 32'd7, 32'hFFFFFFFD, 0, bc, dn, dz);
      chk("mult_busy", bc, 34);
      chk("mult_done", dn, 1);
      chk("mult_dz", dz, 0);
      chk("mult_hi", mif.o_b_mdu_hi, 64'hFFFFFFFF);
      chk("mult_lo", mif.o_b_mdu_lo, 64'hFFFFFFEB);

      // DIVU 100 / 7
      do_op(3'b011, 32'd100, 32'd7, 0, bc, dn, dz);
      chk("divu_busy", bc, 34);
      chk("divu_done", dn, 1);
      chk("divu_dz", dz, 0);
      chk("divu_lo", mif.o_b_mdu_lo, 64'h0000000E);
      chk("divu_hi", mif.o_b_mdu_hi, 64'h00000002);

      // DIV -7 / 2
      do_op(3'b010, 32'hFFFFFFF9, 32'd2, 0, bc, dn, dz);
      chk("div_neg_lo", mif.o_b_mdu_lo, 64'hFFFFFFFD);
      chk("div_neg_hi", mif.o_b_mdu_hi, 64'hFFFFFFFF);

      // DIV 0x80000000 / -1 wraps
      do_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 0, bc, dn, dz);
      chk("div_ovf_done", dn, 1);
      chk("div_ovf_lo", mif.o_b_mdu_lo, 64'h80000000);
      chk("div_ovf_hi", mif.o_b_mdu_hi, 64'h0);

      // MULTU max * max
      do_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, bc, dn, dz);
      chk("multu_max_hi", mif.o_b_mdu_hi, 64'hFFFFFFFE);
      chk("multu_max_lo", mif.o_b_mdu_lo, 64'h00000001);

      // Reserved opcode is a NOP
      do_op(3'b110, 32'h33333333, 32'd1, 0, bc, dn, dz);
      chk("rsv_busy", bc, 0);
      chk("rsv_done", dn, 0);
      chk("rsv_hi", mif.o_b_mdu_hi, 64'hFFFFFFFE);

      // Flush at iteration 10 of MULTU max * max
      do_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, bc, dn, dz);
      chk("flush_busy_cycles", bc, 10);
      chk("flush_done", dn, 0);
      seen_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (mif.o_b_mdu_done || mif.o_b_mdu_busy) seen_done = 1'b1;
      end
      chk("flush_quiet", seen_done, 0);
      chk("flush_hi", mif.o_b_mdu_hi, 64'hFFFFFFFE);
      chk("flush_lo", mif.o_b_mdu_lo, 64'h00000001);
      do_op(3'b001, 32'd3, 32'd4, 0, bc, dn, dz);
      chk("after_flush_lo", mif.o_b_mdu_lo, 64'd12);
      chk("after_flush_hi", mif.o_b_mdu_hi, 64'd0);

      // Flush and start together in IDLE: start discarded
      @(negedge clk);
      mif.i_b_mdu_start = 1'b1;
      mif.i_b_mdu_flush = 1'b1;
      mif.i_b_mdu_op    = 3'b100;
      mif.i_b_mdu_operand_1 = 32'h77777777;
      @(negedge clk);
      mif.i_b_mdu_start = 1'b0;
      mif.i_b_mdu_flush = 1'b0;
      chk("fs_busy", mif.o_b_mdu_busy, 0);
      @(negedge clk);
      chk("fs_done", mif.o_b_mdu_done, 0);
      chk("fs_hi", mif.o_b_mdu_hi, 64'd0);

      // Start during MUL is ignored
      do_op(3'b001, 32'd6, 32'd7, 1, bc, dn, dz);
      chk("poke_busy", bc, 34);
      chk("poke_done", dn, 1);
      chk("poke_lo", mif.o_b_mdu_lo, 64'd42);
      chk("poke_hi", mif.o_b_mdu_hi, 64'd0);
      do_op(3'b100, 32'h0000ABCD, 32'd0, 0, bc, dn, dz);
      chk("poke_mthi", mif.o_b_mdu_hi, 64'h0000ABCD);

      // Asynchronous reset between edges, mid-DIV
      @(negedge clk);
      mif.i_b_mdu_start     = 1'b1;
      mif.i_b_mdu_op        = 3'b011;
      mif.i_b_mdu_operand_1 = 32'd1000;
      mif.i_b_mdu_operand_2 = 32'd3;
      @(negedge clk);
      mif.i_b_mdu_start = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_rst_busy", mif.o_b_mdu_busy, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", mif.o_b_mdu_busy, 0);
      chk("arst_hi", mif.o_b_mdu_hi, 0);
      chk("arst_lo", mif.o_b_mdu_lo, 0);
      chk("arst_done", mif.o_b_mdu_done, 0);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (mif.o_b_mdu_done || mif.o_b_mdu_busy) seen_done = 1'b1;
      end
      chk("arst_quiet", seen_done, 0);

      // First request after reset is accepted
      do_op(3'b001, 32'd3, 32'd4, 0, bc, dn, dz);
      chk("post_rst_busy", bc, 34);
      chk("post_rst_lo", mif.o_b_mdu_lo, 64'd12);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/b_mdu.md
B_MDU -- requirements
Module: b_mdu

Interface
REQ-001 SHALL have no parameters; the operand width is fixed at 32 and the iteration count is fixed at 32.
REQ-002 SHALL have port `i_b_mdu_clk`: input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 SHALL have port `i_b_mdu_rst`: input, 1 bit, reset; asynchronous, active-high.
REQ-004 SHALL have port `i_b_mdu_start`: input, 1 bit, operation request; sampled only in IDLE.
REQ-005 SHALL have port `i_b_mdu_op`: input, 3 bits, opcode.
- 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
- 110 and 111 are reserved (see REQ-021).
REQ-006 SHALL have port `i_b_mdu_operand_1`: input, 32 bits; rs value (multiplicand, dividend, or MTHI/MTLO source).
REQ-007 SHALL have port `i_b_mdu_operand_2`: input, 32 bits; rt value (multiplier or divisor).
REQ-008 SHALL have port `i_b_mdu_flush`: input, 1 bit; pipeline flush, aborts an in-flight operation.
REQ-009 SHALL have port `o_b_mdu_busy`: output, 1 bit; high while an iterative operation is in flight, used as the pipeline stall request.
REQ-010 SHALL have port `o_b_mdu_done`: output, 1 bit; one-cycle completion pulse.
REQ-011 SHALL have port `o_b_mdu_hi`: output, 32 bits; architectural HI register.
REQ-012 SHALL have port `o_b_mdu_lo`: output, 32 bits; architectural LO register.
REQ-013 SHALL have port `o_b_mdu_div_zero`: output, 1 bit; divide-by-zero flag, valid only with `done`.

Function
REQ-014 SHALL implement an FSM with states IDLE, MUL, DIV and FIX.
REQ-015 SHALL, in IDLE with `start`=1 and `flush`=0 and op MULT/MULTU, on the edge (E0):
- latch |operands| for signed ops, or raw operands for unsigned ops;
- latch the result sign;
- clear the 5-bit iteration counter;
- enter MUL.
REQ-016 SHALL, for op DIV/DIVU with operand_2≠0, enter DIV at edge E0, latching as in REQ-015.
REQ-017 SHALL run MUL as radix-2 shift-add with one iteration per cycle, and DIV as restoring shift-subtract with one iteration per cycle; after the 32nd iteration (counter wrap 31→0) the next state is FIX.
REQ-018 SHALL complete FIX in one cycle:
- MUL: negate the 64-bit product if the signs differ.
- DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- HI/LO are written at the FIX exit edge (E0+34); state returns to IDLE.
- MUL: HI = product[63:32], LO = product[31:0].
- DIV: LO = quotient, HI = remainder.
REQ-019 SHALL hold `busy`=1 from after E0 through E0+34 exclusive, and pulse `done`=1 (registered) for exactly the cycle after E0+34.
REQ-020 SHALL treat MTHI/MTLO in IDLE as single-cycle operations:
- write operand_1 to HI/LO at E0;
- `busy` stays 0;
- `done` pulses in the next cycle.
REQ-021 SHALL treat a reserved opcode with `start`=1 as a NOP: no state change, no `done`.
REQ-022 SHALL handle DIV/DIVU with operand_2 = 0 as follows:
- no iteration, `busy` stays 0, HI/LO unchanged;
- `done`=1 and `div_zero`=1 in the next cycle.
REQ-023 SHALL clear `div_zero` on every other `done` pulse.
REQ-024 SHALL ignore `start` while in MUL/DIV/FIX; the in-flight operation continues unaffected.
REQ-025 SHALL handle `flush`=1 in MUL/DIV/FIX as follows:
- next edge goes to IDLE;
- `busy` drops after that edge;
- HI/LO keep their pre-operation values;
- no `done` pulse.
REQ-026 SHALL resolve `flush` and `start` both high in IDLE as flush wins: the start is discarded.
REQ-027 SHALL produce LO=0x80000000 and HI=0 for DIV 0x80000000 / 0xFFFFFFFF (natural wrap, no trap).
REQ-028 SHALL update HI/LO only at the FIX exit edge or on MTHI/MTLO; intermediate results SHALL never be visible on `o_b_mdu_hi` or `o_b_mdu_lo`.

Reset
REQ-029 SHALL, on `i_b_mdu_rst`=1 at any time (including mid-operation), immediately force:
- FSM to IDLE and counter to 0;
- HI=0, LO=0;
- `busy`=0, `done`=0, `div_zero`=0.
REQ-030 SHALL ignore `start` while reset is asserted, and accept it on the first edge after deassertion.

Verification
REQ-031 SHALL cover MULT 7 × 0xFFFFFFFD (−3): `busy` high for 34 cycles; at `done`, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-032 SHALL cover DIVU 100 / 7: LO=0x0000000E, HI=0x00000002, `div_zero`=0; and DIV 0xFFFFFFF9 (−7) / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 SHALL cover DIV 5 / 0 with HI/LO preloaded to 0x11111111/0x22222222 via MTHI/MTLO: `done`=1 and `div_zero`=1 in the next cycle, `busy` never high, HI/LO unchanged.
REQ-034 SHALL cover MULTU 0xFFFFFFFF × 0xFFFFFFFF with `flush` at iteration 10: `busy`=0 after the next edge, no `done`, HI/LO hold their prior values; a new MULTU 3 × 4 started next gives LO=12, HI=0.
REQ-035 SHALL cover `start` asserted during MUL: ignored, original result unchanged.
REQ-036 SHALL cover async reset asserted mid-DIV (between edges): outputs zero immediately, `done` never pulses.
